// File: rtl/qmath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qmath_pkg
//  Description : Shared Q-format helpers: rounding constant and saturation
//                bounds as functions of the word and fractional widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package qmath_pkg;

   // Widest word the helpers below can describe exactly.
   localparam int QMATH_MAX_WIDTH = 64;

   // Half an LSB of the output scale: added before the arithmetic shift
   // to give round-half-up.
   function automatic longint round_const(input int frac_width);
      return 64'sd1 <<< (frac_width - 1);
   endfunction

   // Largest value representable in a signed word of the given width.
   function automatic longint sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   // Most negative value representable in a signed word of the given width.
   function automatic longint sat_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage : qmath_pkg
`default_nettype wire

// File: rtl/qsat.sv
`default_nettype none
// ============================================================================
//  Module      : qsat
//  Description : Combinational clamp of a wide signed value into a signed
//                OUT_WIDTH word, with an overflow indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module qsat
   import qmath_pkg::*;
#(
   parameter int IN_WIDTH  = 33,
   parameter int OUT_WIDTH = 16
) (
   input  logic signed [IN_WIDTH-1:0]  din_i,
   output logic signed [OUT_WIDTH-1:0] dout_o,
   output logic                        ovf_o
);

   // Bounds expressed at the input width so the comparisons are same-width
   // signed compares.
   localparam logic signed [IN_WIDTH-1:0] c_max = IN_WIDTH'(sat_max(OUT_WIDTH));
   localparam logic signed [IN_WIDTH-1:0] c_min = IN_WIDTH'(sat_min(OUT_WIDTH));

   logic w_hi;
   logic w_lo;

   // Clamp to the representable range and flag whenever clamping occurred.
   always_comb begin
      w_hi   = (din_i > c_max);
      w_lo   = (din_i < c_min);
      ovf_o  = w_hi | w_lo;
      dout_o = din_i[OUT_WIDTH-1:0];
      if (w_hi) begin
         dout_o = c_max[OUT_WIDTH-1:0];
      end else if (w_lo) begin
         dout_o = c_min[OUT_WIDTH-1:0];
      end
   end

endmodule : qsat
`default_nettype wire

// File: rtl/axis_qcal.sv
`default_nettype none
// ============================================================================
//  Module      : axis_qcal
//  Description : AXI-Stream gain/offset calibration, y = sat(round(x*gain)
//                + offset), as a two-register pipeline with full backpressure
//                and a sticky saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_qcal
   import qmath_pkg::*;
#(
   parameter int DATA_WIDTH       = 16,
   parameter int FRACTIONAL_WIDTH = 12
) (
   input  logic                         Clk,
   input  logic                         Resetn,
   input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic                         s_axis_tlast,
   input  logic signed [DATA_WIDTH-1:0] gain,
   input  logic signed [DATA_WIDTH-1:0] offset,
   output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic                         sat_flag,
   input  logic                         sat_clear
);

   // Product width, plus one guard bit so rounding and offset never wrap.
   localparam int c_prod_w = 2 * DATA_WIDTH;
   localparam int c_wide_w = 2 * DATA_WIDTH + 1;
   localparam logic signed [c_wide_w-1:0] c_round =
      c_wide_w'(round_const(FRACTIONAL_WIDTH));

   // Stage 1: product, coefficient offset and frame marker of one sample.
   logic                         s1_valid_q, s1_valid_d;
   logic signed [c_prod_w-1:0]   prod_q,     prod_d;
   logic signed [DATA_WIDTH-1:0] off_q,      off_d;
   logic                         s1_last_q,  s1_last_d;

   // Stage 2: calibrated, saturated result presented on the master port.
   logic                         m_valid_q,  m_valid_d;
   logic signed [DATA_WIDTH-1:0] m_data_q,   m_data_d;
   logic                         m_last_q,   m_last_d;
   logic                         sat_flag_q, sat_flag_d;

   logic                         w_en1;
   logic                         w_en2;
   logic signed [c_prod_w-1:0]   w_prod;
   logic signed [c_wide_w-1:0]   w_rnd_sum;
   logic signed [c_wide_w-1:0]   w_shifted;
   logic signed [c_wide_w-1:0]   w_total;
   logic signed [DATA_WIDTH-1:0] w_sat_data;
   logic                         w_ovf;
   logic                         w_sat_evt;

   // Pipeline advance: a stage moves when its successor is empty or draining.
   always_comb begin
      w_en2         = ~m_valid_q | m_axis_tready;
      w_en1         = ~s1_valid_q | w_en2;
      s_axis_tready = w_en1;
   end

   // Full-precision product, then round-half-up, shift and offset add at a
   // width wide enough that none of the intermediate steps can overflow.
   always_comb begin
      w_prod    = c_prod_w'(s_axis_tdata) * c_prod_w'(gain);
      w_rnd_sum = {prod_q[c_prod_w-1], prod_q} + c_round;
      w_shifted = w_rnd_sum >>> FRACTIONAL_WIDTH;
      w_total   = w_shifted + {{(c_wide_w-DATA_WIDTH){off_q[DATA_WIDTH-1]}}, off_q};
   end

   qsat #(
      .IN_WIDTH  (c_wide_w),
      .OUT_WIDTH (DATA_WIDTH)
   ) u_qsat (
      .din_i  (w_total),
      .dout_o (w_sat_data),
      .ovf_o  (w_ovf)
   );

   // Stage-1 next state: capture sample and coefficients together on accept.
   always_comb begin
      s1_valid_d = s1_valid_q;
      prod_d     = prod_q;
      off_d      = off_q;
      s1_last_d  = s1_last_q;
      if (w_en1) begin
         s1_valid_d = s_axis_tvalid;
         if (s_axis_tvalid) begin
            prod_d    = w_prod;
            off_d     = offset;
            s1_last_d = s_axis_tlast;
         end
      end
   end

   // Stage-2 next state and sticky flag; a new saturation beats a clear.
   always_comb begin
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_last_d   = m_last_q;
      w_sat_evt  = w_en2 & s1_valid_q & w_ovf;
      sat_flag_d = w_sat_evt | (sat_flag_q & ~sat_clear);
      if (w_en2) begin
         m_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            m_data_d = w_sat_data;
            m_last_d = s1_last_q;
         end
      end
   end

   // Pipeline registers; reset empties both stages and clears the flag.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         s1_valid_q <= 1'b0;
         prod_q     <= '0;
         off_q      <= '0;
         s1_last_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_last_q   <= 1'b0;
         sat_flag_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         prod_q     <= prod_d;
         off_q      <= off_d;
         s1_last_q  <= s1_last_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_last_q   <= m_last_d;
         sat_flag_q <= sat_flag_d;
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;
   assign sat_flag      = sat_flag_q;

endmodule : axis_qcal
`default_nettype wire

// File: tb/tb_axis_qcal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_qcal
//  Description : Scoreboard bench for axis_qcal: directed corner cases and a
//                randomized run checked against an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_qcal;

   localparam int     DW   = 16;
   localparam int     FW   = 12;
   localparam longint YMAX = 32767;
   localparam longint YMIN = -32768;

   logic                 Clk = 1'b0;
   logic                 Resetn = 1'b0;
   logic signed [DW-1:0] s_tdata = '0;
   logic                 s_tvalid = 1'b0;
   logic                 s_tready;
   logic                 s_tlast = 1'b0;
   logic signed [DW-1:0] gain = '0;
   logic signed [DW-1:0] offset = '0;
   logic signed [DW-1:0] m_tdata;
   logic                 m_tvalid;
   logic                 m_tready;
   logic                 m_tlast;
   logic                 sat_flag;
   logic                 sat_clear = 1'b0;

   typedef struct {
      logic signed [DW-1:0] d;
      logic                 l;
      bit                   s;
   } exp_t;

   exp_t   sb[$];
   int     pop_log[$];
   int     n_checks = 0;
   int     n_fail = 0;
   int     cyc = 0;
   int     acc_cnt = 0;
   bit     ready_mode = 1'b0;
   logic   ready_val = 1'b1;

   axis_qcal #(
      .DATA_WIDTH       (DW),
      .FRACTIONAL_WIDTH (FW)
   ) dut (
      .Clk           (Clk),
      .Resetn        (Resetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .gain          (gain),
      .offset        (offset),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .sat_flag      (sat_flag),
      .sat_clear     (sat_clear)
   );

   initial forever #5 Clk = ~Clk;

   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   // Downstream ready: fixed level or random, changed just after each edge.
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         m_tready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_val;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Reference: the calibration formula evaluated with 64-bit integers.
   function automatic exp_t model(input longint x, input longint g,
                                  input longint o, input logic l);
      exp_t   e;
      longint y;
      y   = ((x * g + (64'sd1 <<< (FW - 1))) >>> FW) + o;
      e.s = (y > YMAX) || (y < YMIN);
      if (y > YMAX) y = YMAX;
      else if (y < YMIN) y = YMIN;
      e.d = DW'(y);
      e.l = l;
      return e;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present one sample and hold it until accepted; record its expectation.
   task automatic send(input logic signed [DW-1:0] x, input logic signed [DW-1:0] g,
                       input logic signed [DW-1:0] o, input logic l);
      @(posedge Clk);
      #1;
      s_tvalid = 1'b1;
      s_tdata  = x;
      gain     = g;
      offset   = o;
      s_tlast  = l;
      for (int k = 0; k < 200; k++) begin
         @(negedge Clk);
         if (s_tready) begin
            sb.push_back(model(longint'(x), longint'(g), longint'(o), l));
            acc_cnt++;
            return;
         end
      end
      check("send_timeout", 0, 1);
   endtask

   task automatic idle();
      @(posedge Clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge Clk);
         done = (sb.size() == 0) && !m_tvalid;
      end
      check("drain_complete", longint'(done), 1);
   endtask

   task automatic clear_flag();
      @(posedge Clk);
      #1;
      sat_clear = 1'b1;
      @(posedge Clk);
      #1;
      sat_clear = 1'b0;
      @(negedge Clk);
      check("sat_cleared", longint'(sat_flag), 0);
   endtask

   // Monitor: pop on every output transfer, and check held outputs are stable.
   initial begin
      bit                   hold;
      logic signed [DW-1:0] hd;
      logic                 hl;
      hold = 1'b0;
      hd   = '0;
      hl   = 1'b0;
      forever begin
         @(negedge Clk);
         if (!Resetn) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("hold_valid", longint'(m_tvalid), 1);
               check("hold_data", longint'(m_tdata), longint'(hd));
               check("hold_last", longint'(m_tlast), longint'(hl));
            end
            if (m_tvalid && m_tready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", longint'(m_tdata), -99999);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("out_data", longint'(m_tdata), longint'(e.d));
                  check("out_last", longint'(m_tlast), longint'(e.l));
                  if (e.s) check("sat_flag_on_sat", longint'(sat_flag), 1);
                  pop_log.push_back(cyc);
               end
            end
            hold = m_tvalid && !m_tready;
            hd   = m_tdata;
            hl   = m_tlast;
         end
      end
   end

   initial begin
      int  base;
      bit  seen;
      logic signed [DW-1:0] rx, rg, ro;

      // Reset state, with the first sample already presented.
      repeat (3) @(negedge Clk);
      check("rst_m_valid", longint'(m_tvalid), 0);
      check("rst_s_ready", longint'(s_tready), 1);
      check("rst_sat_flag", longint'(sat_flag), 0);
      check("rst_m_data", longint'(m_tdata), 0);
      check("rst_m_last", longint'(m_tlast), 0);
      s_tvalid = 1'b1;
      s_tdata  = 16'sd1000;
      gain     = 16'sh1000;
      offset   = 16'sd0;
      Resetn   = 1'b1;
      sb.push_back(model(1000, 4096, 0, 1'b0));
      @(posedge Clk);
      #1;
      s_tvalid = 1'b0;
      @(negedge Clk);
      check("lat_cycle1_empty", longint'(m_tvalid), 0);
      @(negedge Clk);
      check("lat_cycle2_valid", longint'(m_tvalid), 1);
      check("unity_gain_data", longint'(m_tdata), 1000);
      check("unity_gain_noflag", longint'(sat_flag), 0);
      drain();

      // Rounding half-up on both signs, back to back.
      pop_log.delete();
      send(16'sd3, 16'sh0800, 16'sd0, 1'b0);
      send(-16'sd3, 16'sh0800, 16'sd0, 1'b0);
      idle();
      drain();
      check("round_pair_count", longint'(pop_log.size()), 2);
      if (pop_log.size() == 2)
         check("round_pair_consecutive", longint'(pop_log[1] - pop_log[0]), 1);

      // Positive saturation, -1.0 * min overflow, then clear.
      send(16'sd20000, 16'sh2000, 16'sd0, 1'b0);
      idle();
      drain();
      check("sat_set", longint'(sat_flag), 1);
      send(-16'sd32768, 16'shF000, 16'sd0, 1'b0);
      idle();
      drain();
      clear_flag();

      // Clear and a saturation event in the same cycle: set wins.
      send(16'sd20000, 16'sh2000, 16'sd0, 1'b0);
      @(posedge Clk);
      #1;
      s_tvalid  = 1'b0;
      sat_clear = 1'b1;
      @(posedge Clk);
      #1;
      sat_clear = 1'b0;
      @(negedge Clk);
      check("sat_set_priority", longint'(sat_flag), 1);
      drain();
      clear_flag();

      // Offset add, negative and into saturation.
      send(16'sd100, 16'sh1000, -16'sd200, 1'b0);
      send(16'sd32767, 16'sh1000, 16'sd10, 1'b0);
      idle();
      drain();
      check("offset_sat_flag", longint'(sat_flag), 1);
      clear_flag();

      // Five back-to-back samples with downstream stalled for edges 2..6.
      pop_log.delete();
      base = acc_cnt;
      fork
         begin
            for (int i = 1; i <= 5; i++)
               send(DW'(i * 1000), 16'sh1000, DW'(i), (i == 5));
            idle();
         end
         begin
            seen = 1'b0;
            for (int k = 0; k < 100 && !seen; k++) begin
               @(posedge Clk);
               seen = (acc_cnt != base);
            end
            check("bp_first_accept", longint'(seen), 1);
            ready_val = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            check("bp_s_ready_dropped", longint'(s_tready), 0);
            check("bp_two_held_valid", longint'(m_tvalid), 1);
            check("bp_two_accepted", longint'(acc_cnt - base), 2);
            repeat (4) @(posedge Clk);
            ready_val = 1'b1;
         end
      join
      drain();
      check("bp_all_emerged", longint'(pop_log.size()), 5);

      // Reset with two samples in flight.
      ready_val = 1'b0;
      @(posedge Clk);
      send(16'sd500, 16'sh1000, 16'sd0, 1'b0);
      send(16'sd600, 16'sh1000, 16'sd0, 1'b0);
      @(posedge Clk);
      #1;
      s_tvalid = 1'b0;
      check("pre_reset_held", longint'(m_tvalid), 1);
      Resetn = 1'b0;
      #1;
      check("reset_m_valid_now", longint'(m_tvalid), 0);
      check("reset_s_ready_now", longint'(s_tready), 1);
      sb.delete();
      ready_val = 1'b1;
      repeat (2) @(negedge Clk);
      Resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         check("no_stale_output", longint'(m_tvalid), 0);
      end
      send(-16'sd1234, 16'sh1000, 16'sd0, 1'b1);
      idle();
      drain();

      // Randomized traffic with random downstream backpressure.
      ready_mode = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) idle();
         rx = DW'($urandom);
         if ($urandom_range(0, 1) == 0) rg = DW'($urandom_range(0, 16383)) - 16'sd8192;
         else rg = DW'($urandom);
         if ($urandom_range(0, 1) == 0) ro = DW'($urandom_range(0, 511)) - 16'sd256;
         else ro = DW'($urandom);
         send(rx, rg, ro, ($urandom_range(0, 7) == 0));
      end
      idle();
      ready_mode = 1'b0;
      ready_val  = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_axis_qcal
`default_nettype wire
